// File: rtl/food_placer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : food_placer                                                     |
// | Purpose  : Picks a free board cell for new food using an LFSR plus an      |
// |            occupancy lookup; optional linear-scan fallback (FOOD_SCAN_EN). |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module food_placer #(
    parameter int GRID_BITS = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   place_req,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [GRID_BITS-1:0]   food_x,
    output logic [GRID_BITS-1:0]   food_y,
    output logic                   occ_rd,
    output logic [2*GRID_BITS-1:0] occ_addr,
    input  logic                   occ_hit
);
    localparam int                    c_ADDR_W    = 2 * GRID_BITS;
    localparam int                    c_TRY_W     = $clog2(MAX_TRIES + 1);
    localparam logic [8:0]            c_SEED      = 9'b110110110;
    localparam logic [GRID_BITS-1:0]  c_FOOD_RST  = GRID_BITS'(1 << (GRID_BITS - 1));
    localparam logic [c_TRY_W-1:0]    c_MAX_TRIES = c_TRY_W'(MAX_TRIES);
    localparam logic [c_TRY_W-1:0]    c_TRY_ONE   = 1;
    localparam logic [c_ADDR_W-1:0]   c_ADDR_ONE  = 1;
    localparam logic [c_ADDR_W:0]     c_CNT_ONE   = 1;
    localparam logic [c_ADDR_W:0]     c_CELLS     = {1'b1, {c_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SAMPLE   = 3'd1,
        S_CHECK    = 3'd2,
        S_SCAN     = 3'd3,
        S_SCAN_CHK = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [8:0]            r_lfsr;
    logic [c_ADDR_W-1:0]   r_cand, w_cand_nxt;
    logic [c_TRY_W-1:0]    r_tries, w_tries_nxt;
    logic                  r_fail, w_fail_nxt;
    logic [GRID_BITS-1:0]  r_food_x, w_food_x_nxt;
    logic [GRID_BITS-1:0]  r_food_y, w_food_y_nxt;
    logic                  w_occ_rd;
    logic [c_ADDR_W-1:0]   w_occ_addr;
`ifdef FOOD_SCAN_EN
    logic [c_ADDR_W-1:0]   r_scan_addr, w_scan_addr_nxt;
    logic [c_ADDR_W:0]     r_scan_cnt, w_scan_cnt_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_lfsr   <= c_SEED;
            r_cand   <= '0;
            r_tries  <= '0;
            r_fail   <= 1'b0;
            r_food_x <= c_FOOD_RST;
            r_food_y <= c_FOOD_RST;
        end else begin
            r_state  <= w_state_nxt;
            // XNOR feedback: the all-ones word is the only lockup state
            r_lfsr   <= {r_lfsr[7:0], ~(r_lfsr[8] ^ r_lfsr[4])};
            r_cand   <= w_cand_nxt;
            r_tries  <= w_tries_nxt;
            r_fail   <= w_fail_nxt;
            r_food_x <= w_food_x_nxt;
            r_food_y <= w_food_y_nxt;
        end
    end

`ifdef FOOD_SCAN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_addr <= '0;
            r_scan_cnt  <= '0;
        end else begin
            r_scan_addr <= w_scan_addr_nxt;
            r_scan_cnt  <= w_scan_cnt_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_tries_nxt  = r_tries;
        w_fail_nxt   = r_fail;
        w_food_x_nxt = r_food_x;
        w_food_y_nxt = r_food_y;
        w_occ_rd     = 1'b0;
        w_occ_addr   = r_cand;
`ifdef FOOD_SCAN_EN
        w_scan_addr_nxt = r_scan_addr;
        w_scan_cnt_nxt  = r_scan_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (place_req) begin
                    w_state_nxt = S_SAMPLE;
                    w_tries_nxt = '0;
                    w_fail_nxt  = 1'b0;
                end
            end
            S_SAMPLE: begin
                w_occ_rd    = 1'b1;
                w_occ_addr  = r_lfsr[c_ADDR_W-1:0];
                w_cand_nxt  = r_lfsr[c_ADDR_W-1:0];
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!occ_hit) begin
                    w_food_y_nxt = r_cand[c_ADDR_W-1:GRID_BITS];
                    w_food_x_nxt = r_cand[GRID_BITS-1:0];
                    w_fail_nxt   = 1'b0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_tries_nxt = r_tries + c_TRY_ONE;
                    if (w_tries_nxt == c_MAX_TRIES) begin
`ifdef FOOD_SCAN_EN
                        w_scan_addr_nxt = r_cand + c_ADDR_ONE;
                        w_scan_cnt_nxt  = '0;
                        w_state_nxt     = S_SCAN;
`else
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_state_nxt = S_SAMPLE;
                    end
                end
            end
`ifdef FOOD_SCAN_EN
            S_SCAN: begin
                w_occ_rd    = 1'b1;
                w_occ_addr  = r_scan_addr;
                w_state_nxt = S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                if (!occ_hit) begin
                    w_food_y_nxt = r_scan_addr[c_ADDR_W-1:GRID_BITS];
                    w_food_x_nxt = r_scan_addr[GRID_BITS-1:0];
                    w_fail_nxt   = 1'b0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_scan_addr_nxt = r_scan_addr + c_ADDR_ONE;
                    w_scan_cnt_nxt  = r_scan_cnt + c_CNT_ONE;
                    if (w_scan_cnt_nxt == c_CELLS) begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SCAN;
                    end
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign fail     = r_fail;
    assign food_x   = r_food_x;
    assign food_y   = r_food_y;
    assign occ_rd   = w_occ_rd;
    assign occ_addr = w_occ_addr;

endmodule
`default_nettype wire
